gpio_edge_pio: RTL and testbench

Parametrised successor to the fixed-width button/dipsw/LED PIO peripherals in the HPS lightweight-bridge fabric. One Avalon-MM slave provides WIDTH general-purpose bits with per-bit direction, output set/clear, a two-flop input synchroniser, an optional per-bit debouncer, rising/falling edge capture and a masked level interrupt to the HPS. Pad tristating is left to the top level, which is driven from `gpio_out`/`gpio_oe`.

---
 rtl/gpio_edge_pio.sv | 165 ++++++++++++++++
 tb/tb_gpio_edge_pio.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_edge_pio.sv
// gpio_edge_pio: WIDTH-bit Avalon-MM GPIO block with per-bit direction,
// output set/clear, two-flop input synchroniser, optional debouncer,
// rising/falling edge capture and a masked, registered level interrupt.
module gpio_edge_pio #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_CYCLES = 0,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0,
    parameter logic [WIDTH-1:0] DIR_RESET       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe
);

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_DIR      = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_EDGE_CAP = 3'd3,
        ADDR_OUT_SET  = 3'd4,
        ADDR_OUT_CLR  = 3'd5,
        ADDR_RISE_EN  = 3'd6,
        ADDR_FALL_EN  = 3'd7
    } addr_e;

    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c;
    logic [31:0]      rd_word;
    logic             unused_wd;

    // Bits of writedata above WIDTH carry no meaning for this block.
    assign wdata     = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    assign gpio_out = out_reg;
    assign gpio_oe  = dir_reg;

    // Control registers: address 0, 4 and 5 are the only writers of OUT.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values;
        // blocking assignments here would create order-dependent simulation.
        if (reset) begin
            out_reg  <= OUT_RESET;
            dir_reg  <= DIR_RESET;
            irq_mask <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
        end else if (write) begin
            case (address)
                ADDR_DATA:     out_reg  <= wdata;
                ADDR_DIR:      dir_reg  <= wdata;
                ADDR_IRQ_MASK: irq_mask <= wdata;
                ADDR_OUT_SET:  out_reg  <= out_reg | wdata;
                ADDR_OUT_CLR:  out_reg  <= out_reg & ~wdata;
                ADDR_RISE_EN:  rise_en  <= wdata;
                ADDR_FALL_EN:  fall_en  <= wdata;
                default:       ;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= gpio_in;
            sync      <= sync_meta;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign deb = sync;
        end else begin : g_debounce
            localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
            logic [15:0] cnt [WIDTH];

            // Per-bit debouncer: accept sync only after it has differed from
            // deb for DEBOUNCE_CYCLES consecutive samples.
            always_ff @(posedge clk) begin
                for (int i = 0; i < WIDTH; i++) begin
                    // NOTE: the counter array is reset explicitly; a stale count
                    // after reset could accept a glitch early.
                    if (reset) begin
                        cnt[i] <= '0;
                        deb[i] <= 1'b0;
                    end else if (sync[i] == deb[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        deb[i] <= sync[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 16'd1;
                    end
                end
            end
        end
    endgenerate

    assign edge_set = (deb & ~deb_d & rise_en) | (~deb & deb_d & fall_en);
    assign w1c      = (write && (address == ADDR_EDGE_CAP)) ? wdata : '0;

    // Edge capture: a new edge wins over a simultaneous W1C on the same bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_d    <= '0;
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            deb_d    <= deb;
            edge_cap <= (edge_cap & ~w1c) | edge_set;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    // Read mux: zero-extends the WIDTH-bit register to the 32-bit bus.
    always_comb begin
        // NOTE: default first so no path through the case leaves rd_word
        // unassigned, which would infer a latch.
        rd_word = '0;
        case (address)
            ADDR_DATA:     rd_word[WIDTH-1:0] = deb;
            ADDR_DIR:      rd_word[WIDTH-1:0] = dir_reg;
            ADDR_IRQ_MASK: rd_word[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_word[WIDTH-1:0] = edge_cap;
            ADDR_OUT_SET:  rd_word[WIDTH-1:0] = out_reg;
            ADDR_OUT_CLR:  rd_word[WIDTH-1:0] = out_reg;
            ADDR_RISE_EN:  rd_word[WIDTH-1:0] = rise_en;
            ADDR_FALL_EN:  rd_word[WIDTH-1:0] = fall_en;
            default:       rd_word = '0;
        endcase
    end

    // Registered read data, one cycle after the read strobe; a concurrent
    // write is not yet visible so the pre-write value is returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_gpio_edge_pio.sv
// Self-checking bench for gpio_edge_pio: one instance with a 4-cycle
// debouncer and one with the debouncer bypassed, sharing the bus.
module tb_gpio_edge_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata_a, readdata_b;
    logic        irq_a, irq_b;
    logic [7:0]  gpio_in_a, gpio_in_b;
    logic [7:0]  gpio_out_a, gpio_out_b;
    logic [7:0]  gpio_oe_a, gpio_oe_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    gpio_edge_pio #(
        .WIDTH(8), .DEBOUNCE_CYCLES(4), .OUT_RESET(8'hA5), .DIR_RESET(8'h0F)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata_a), .irq(irq_a),
        .gpio_in(gpio_in_a), .gpio_out(gpio_out_a), .gpio_oe(gpio_oe_a)
    );

    gpio_edge_pio #(
        .WIDTH(8), .DEBOUNCE_CYCLES(0), .OUT_RESET(8'hA5), .DIR_RESET(8'h0F)
    ) dut0 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata_b), .irq(irq_b),
        .gpio_in(gpio_in_b), .gpio_out(gpio_out_b), .gpio_oe(gpio_oe_b)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] ra, output logic [31:0] rb);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        ra = readdata_a;
        rb = readdata_b;
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] a, input logic [31:0] d,
                                input logic [31:0] e, input string n);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp = e; v.name = n;
        return v;
    endfunction

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;

        vecs.push_back(mk(1, 3'd0, 32'h3C,         32'h0,  "w_data"));
        vecs.push_back(mk(1, 3'd4, 32'h81,         32'h0,  "w_set"));
        vecs.push_back(mk(1, 3'd5, 32'h0C,         32'h0,  "w_clr"));
        vecs.push_back(mk(0, 3'd4, 32'h0,          32'hB1, "rd_out_set"));
        vecs.push_back(mk(0, 3'd5, 32'h0,          32'hB1, "rd_out_clr"));
        vecs.push_back(mk(0, 3'd0, 32'h0,          32'h00, "rd_data_in"));
        vecs.push_back(mk(1, 3'd1, 32'hF0,         32'h0,  "w_dir"));
        vecs.push_back(mk(0, 3'd1, 32'h0,          32'hF0, "rd_dir"));
        vecs.push_back(mk(1, 3'd2, 32'h12345603,   32'h0,  "w_mask"));
        vecs.push_back(mk(0, 3'd2, 32'h0,          32'h03, "rd_mask_hi_zero"));
        vecs.push_back(mk(1, 3'd6, 32'hFFFFFF55,   32'h0,  "w_rise"));
        vecs.push_back(mk(0, 3'd6, 32'h0,          32'h55, "rd_rise"));
        vecs.push_back(mk(1, 3'd7, 32'hAA,         32'h0,  "w_fall"));
        vecs.push_back(mk(0, 3'd7, 32'h0,          32'hAA, "rd_fall"));
        vecs.push_back(mk(1, 3'd6, 32'h0,          32'h0,  "w_rise0"));
        vecs.push_back(mk(1, 3'd7, 32'h0,          32'h0,  "w_fall0"));
        vecs.push_back(mk(1, 3'd2, 32'h0,          32'h0,  "w_mask0"));
        vecs.push_back(mk(0, 3'd3, 32'h0,          32'h00, "rd_edge_none"));

        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
        gpio_in_a = '0; gpio_in_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset values.
        check("rst_gpio_out", 32'(gpio_out_a), 32'hA5);
        check("rst_gpio_oe",  32'(gpio_oe_a),  32'h0F);
        check("rst_irq",      32'(irq_a),      32'h0);
        bus_read(3'd3, ra, rb);
        check("rst_edge_cap", ra, 32'h0);

        // Register table.
        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else begin
                bus_read(vecs[i].addr, ra, rb);
                check(vecs[i].name, ra, vecs[i].exp);
            end
        end
        check("gpio_out_after_setclr", 32'(gpio_out_a), 32'hB1);
        check("gpio_oe_after_write",   32'(gpio_oe_a),  32'hF0);

        // Read and write in the same cycle: pre-write value returned.
        @(negedge clk);
        address = 3'd1; writedata = 32'h3C; write = 1'b1; read = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        check("rw_same_cycle_old", readdata_a, 32'hF0);
        bus_read(3'd1, ra, rb);
        check("rw_same_cycle_new", ra, 32'h3C);

        // Debounce: a 3-cycle pulse must be rejected.
        bus_write(3'd6, 32'h01);
        bus_write(3'd2, 32'h01);
        gpio_in_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        gpio_in_a[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_irq", 32'(irq_a), 32'h0);
        bus_read(3'd3, ra, rb);
        check("glitch_edge_cap", ra, 32'h0);
        bus_read(3'd0, ra, rb);
        check("glitch_data", ra, 32'h0);

        // Held input: irq rises exactly 8 cycles after the input.
        gpio_in_a[0] = 1'b1;
        repeat (7) @(negedge clk);
        check("hold_irq_cycle7", 32'(irq_a), 32'h0);
        @(negedge clk);
        check("hold_irq_cycle8", 32'(irq_a), 32'h1);
        bus_read(3'd3, ra, rb);
        check("hold_edge_cap", ra, 32'h01);
        bus_read(3'd0, ra, rb);
        check("hold_data", ra, 32'h01);

        // Drop bit0 (falling edges disabled) and raise it again so the new
        // capture lands on the same edge as a W1C write.
        gpio_in_a[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("fall_ignored_irq", 32'(irq_a), 32'h1);
        gpio_in_a[0] = 1'b1;
        repeat (6) @(negedge clk);
        address = 3'd3; writedata = 32'h01; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        check("w1c_vs_edge_irq", 32'(irq_a), 32'h1);
        bus_read(3'd3, ra, rb);
        check("w1c_vs_edge_cap", ra, 32'h01);
        bus_write(3'd3, 32'h01);
        check("w1c_irq_same_cycle", 32'(irq_a), 32'h1);
        @(negedge clk);
        check("w1c_irq_dropped", 32'(irq_a), 32'h0);

        // Debouncer bypassed: only the falling edge of a 0->1->0 is captured.
        bus_write(3'd6, 32'h00);
        bus_write(3'd7, 32'h02);
        bus_write(3'd2, 32'h02);
        bus_write(3'd3, 32'hFF);
        gpio_in_b[1] = 1'b1;
        repeat (2) @(negedge clk);
        gpio_in_b[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("nodeb_no_rise_irq", 32'(irq_b), 32'h0);
        @(negedge clk);
        check("nodeb_irq_cycle5", 32'(irq_b), 32'h0);
        @(negedge clk);
        check("nodeb_irq_cycle6", 32'(irq_b), 32'h1);
        bus_read(3'd3, ra, rb);
        check("nodeb_edge_cap", rb, 32'h02);

        // Fill EDGE_CAP with all ones, then reset mid-debounce.
        bus_write(3'd6, 32'hFF);
        bus_write(3'd7, 32'hFF);
        bus_write(3'd2, 32'hFF);
        gpio_in_a = 8'hFF;
        repeat (12) @(negedge clk);
        gpio_in_a = 8'hFE;
        repeat (12) @(negedge clk);
        bus_read(3'd3, ra, rb);
        check("full_edge_cap", ra, 32'hFF);
        check("full_irq", 32'(irq_a), 32'h1);
        gpio_in_a = 8'h00;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_irq",      32'(irq_a),      32'h0);
        check("midrst_gpio_out", 32'(gpio_out_a), 32'hA5);
        check("midrst_gpio_oe",  32'(gpio_oe_a),  32'h0F);
        check("midrst_readdata", readdata_a,      32'h0);
        repeat (10) @(negedge clk);
        bus_read(3'd3, ra, rb);
        check("midrst_edge_cap", ra, 32'h0);
        bus_read(3'd2, ra, rb);
        check("midrst_mask", ra, 32'h0);
        bus_read(3'd6, ra, rb);
        check("midrst_rise_en", ra, 32'h0);
        check("midrst_irq_late", 32'(irq_a), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
